// File: rtl/data_memory_mc.sv
// data_memory_mc: multi-cycle big-endian byte-addressed data memory with fault detection
//   Params : DEPTH_BYTES (array bytes, multiple of 4), LATENCY (1..15 cycles accept->execute)
//   Inputs : clk, startin (sync active-high reset), Address, WriteData, MemWrite, MemRead,
//            Size (00 byte, 01 half, 10 word), Unsigned (zero-extend loads)
//   Outputs: ReadData (held between loads), Stall (BUSY), Done (completion pulse), Fault (with Done)
//   Option : DMEM_PRELOAD_EN -> reset loads word i with i+1, last word with 0
module data_memory_mc #(
  parameter int DEPTH_BYTES = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        startin,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        Fault
);
  localparam int AW = $clog2(DEPTH_BYTES);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, stateNext;
  logic [3:0] cnt, cntNext;
  logic [7:0] mem [DEPTH_BYTES];
  logic [AW-1:0] addrQ;
  logic [31:0] dataQ, loadVal;
  logic [1:0] sizeQ;
  logic unsQ, writeQ, faultQ, req, reqFault, exec;
  logic [2:0] nBytes;
  logic [7:0] b0, b1, b2, b3;
  assign req = state != BUSY && (MemRead || MemWrite);
  assign nBytes = Size == 2'b00 ? 3'd1 : Size == 2'b01 ? 3'd2 : 3'd4;
  // range check uses the full 32-bit address with a carry bit so wrap-around cannot hide overflow
  assign reqFault = Size == 2'b11 || (MemRead && MemWrite) || (Size == 2'b01 && Address[0]) ||
                    (Size == 2'b10 && Address[1:0] != 2'b00) ||
                    {1'b0, Address} + 33'(nBytes) > 33'(DEPTH_BYTES);
  assign exec = state == BUSY && cnt == 4'd0;
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    if (state == BUSY) begin
      stateNext = cnt == 4'd0 ? DONE : BUSY;
      cntNext = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
    end else if (req) begin
      stateNext = reqFault ? DONE : BUSY;
      cntNext = reqFault ? 4'd0 : 4'(LATENCY - 1);
    end else stateNext = IDLE;
  end
  always_ff @(posedge clk) begin
    if (startin) begin
      state <= IDLE;
      cnt <= 4'd0;
      ReadData <= 32'd0;
      faultQ <= 1'b0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      if (req) begin
        addrQ <= Address[AW-1:0];
        dataQ <= WriteData;
        sizeQ <= Size;
        unsQ <= Unsigned;
        writeQ <= MemWrite;
        faultQ <= reqFault;
      end
      if (exec && !writeQ) ReadData <= loadVal;
    end
  end
  assign Stall = state == BUSY;
  assign Done = state == DONE;
  assign Fault = Done && faultQ;
  // byte at the latched address is the most significant byte of the unit
  assign b0 = mem[addrQ];
  assign b1 = mem[addrQ + AW'(1)];
  assign b2 = mem[addrQ + AW'(2)];
  assign b3 = mem[addrQ + AW'(3)];
  assign loadVal = sizeQ == 2'b00 ? {{24{!unsQ && b0[7]}}, b0} :
                   sizeQ == 2'b01 ? {{16{!unsQ && b0[7]}}, b0, b1} : {b0, b1, b2, b3};
  always_ff @(posedge clk) begin
`ifdef DMEM_PRELOAD_EN
    if (startin) begin
      for (int i = 0; i < DEPTH_BYTES; i++)
        mem[i] <= 8'((i / 4 < DEPTH_BYTES / 4 - 1 ? i / 4 + 1 : 0) >> (8 * (3 - i % 4)));
    end else
`endif
    if (exec && writeQ && !startin) begin
      mem[addrQ] <= sizeQ == 2'b00 ? dataQ[7:0] : sizeQ == 2'b01 ? dataQ[15:8] : dataQ[31:24];
      if (sizeQ != 2'b00) mem[addrQ + AW'(1)] <= sizeQ == 2'b01 ? dataQ[7:0] : dataQ[23:16];
      if (sizeQ == 2'b10) begin
        mem[addrQ + AW'(2)] <= dataQ[15:8];
        mem[addrQ + AW'(3)] <= dataQ[7:0];
      end
    end
  end
endmodule

// File: tb/tb_data_memory_mc.sv
// tb_data_memory_mc: randomized and directed checks of data_memory_mc against a byte-array model
module tb_data_memory_mc;
  localparam int DEPTH = 64;
  localparam int LAT = 2;
  logic clk = 1'b0, rst;
  logic [31:0] addr, wdata, rdata;
  logic rd, wr, uns, stall, done, fault;
  logic [1:0] size;
  logic [31:0] a1, wd1, rdata1;
  logic rd1, wr1, stall1, done1, fault1;
  int total = 0, bad = 0;
  logic [7:0] m [DEPTH];
  logic [31:0] expRd;
  data_memory_mc #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .startin(rst), .Address(addr), .WriteData(wdata), .MemWrite(wr), .MemRead(rd),
    .Size(size), .Unsigned(uns), .ReadData(rdata), .Stall(stall), .Done(done), .Fault(fault));
  data_memory_mc #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .startin(rst), .Address(a1), .WriteData(wd1), .MemWrite(wr1), .MemRead(rd1),
    .Size(2'b10), .Unsigned(1'b0), .ReadData(rdata1), .Stall(stall1), .Done(done1), .Fault(fault1));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] modelLoad(int a, int s, bit u);
    int nb;
    longint v;
    nb = 1 << s;
    v = 0;
    for (int j = 0; j < nb; j++) v = (v << 8) | longint'(m[a + j]);
    if (!u && nb < 4 && v[8 * nb - 1]) v = v - (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction
  function automatic bit modelFault(longint a, int s, bit r, bit w);
    int nb;
    nb = 1 << s;
    return s == 3 || (r && w) || a % nb != 0 || a + nb > DEPTH;
  endfunction
  task automatic modelReset();
    expRd = 32'd0;
`ifdef DMEM_PRELOAD_EN
    for (int w = 0; w < DEPTH / 4; w++)
      {m[4 * w], m[4 * w + 1], m[4 * w + 2], m[4 * w + 3]} = w < DEPTH / 4 - 1 ? 32'(w + 1) : 32'h0;
`endif
  endtask
  task automatic access(input logic [31:0] a, input logic [31:0] d, input int s, input bit u, input bit r, input bit w);
    bit f;
    int n, nb;
    f = modelFault({32'd0, a}, s, r, w);
    nb = 1 << s;
    addr = a; wdata = d; size = 2'(s); uns = u; rd = r; wr = w;
    @(negedge clk);
    addr = $urandom; wdata = $urandom; size = 2'($urandom); uns = 1'($urandom);
    rd = 1'($urandom); wr = 1'($urandom);
    if (!f) begin
      n = 0;
      while (stall === 1'b1 && n < 20) begin
        n++;
        @(negedge clk);
      end
      check("stallCycles", n, LAT);
      if (r) expRd = modelLoad(int'(a), s, u);
      else for (int j = 0; j < nb; j++) m[int'(a) + j] = 8'(d >> (8 * (nb - 1 - j)));
    end
    check("done", done, 1);
    check("fault", fault, 32'(f));
    check("stallLow", stall, 0);
    check(r && !f ? "load" : "rdHold", rdata, expRd);
  endtask
  task automatic idle();
    rd = 0; wr = 0;
    @(negedge clk);
    check("doneDrop", done, 0);
  endtask
  initial begin
    rst = 1; rd = 0; wr = 0; addr = 0; wdata = 0; size = 0; uns = 0;
    rd1 = 0; wr1 = 0; a1 = 0; wd1 = 0;
    repeat (2) @(negedge clk);
    check("rstRdata", rdata, 0);
    check("rstStall", stall, 0);
    check("rstDone", done, 0);
    check("rstFault", fault, 0);
    rst = 0;
    modelReset();
`ifdef DMEM_PRELOAD_EN
    access(8, 0, 2, 0, 1, 0);
    check("preload8", rdata, 32'h3);
    idle();
`endif
    a1 = 0; wd1 = 32'h12345678; wr1 = 1;
    @(negedge clk);
    check("b2bStall", stall1, 1);
    wr1 = 0;
    @(negedge clk);
    check("b2bDoneSt", done1, 1);
    check("b2bFaultSt", fault1, 0);
    rd1 = 1;
    @(negedge clk);
    rd1 = 0;
    check("b2bGap", done1, 0);
    @(negedge clk);
    check("b2bDoneLd", done1, 1);
    check("b2bData", rdata1, 32'h12345678);
    for (int w = 0; w < DEPTH / 4; w++) access(32'(4 * w), $urandom, 2, 0, 0, 1);
    idle();
    access(32'h10, 32'h5, 2, 0, 0, 1);
    access(32'h11, 32'hABCDEFF0, 0, 0, 0, 1);
    access(32'h10, 0, 2, 0, 1, 0);
    check("planWord", rdata, 32'h00F00005);
    access(32'h11, 0, 0, 0, 1, 0);
    check("planSByte", rdata, 32'hFFFFFFF0);
    access(32'h11, 0, 0, 1, 1, 0);
    check("planUByte", rdata, 32'h000000F0);
    access(32'h22, 32'h55558001, 1, 0, 0, 1);
    access(32'h22, 0, 1, 0, 1, 0);
    check("planSHalf", rdata, 32'hFFFF8001);
    access(32'h22, 0, 1, 1, 1, 0);
    check("planUHalf", rdata, 32'h00008001);
    idle();
    access(32'h6, 0, 2, 0, 1, 0);
    access(DEPTH - 2, 32'hFFFFFFFF, 2, 0, 0, 1);
    access(DEPTH - 4, 0, 2, 0, 1, 0);
    access(0, 0, 2, 0, 1, 1);
    access(32'h100, 0, 2, 0, 1, 0);
    access(32'hFFFFFFFC, 0, 2, 0, 1, 0);
    access(0, 0, 3, 0, 1, 0);
    access(1, 0, 1, 0, 1, 0);
    access(DEPTH - 1, 32'h7E, 0, 0, 0, 1);
    access(DEPTH - 2, 0, 1, 0, 1, 0);
    idle();
    addr = 4; wdata = 32'hDEADBEEF; size = 2; uns = 0; wr = 1; rd = 0;
    @(negedge clk);
    wr = 0;
    check("midBusy", stall, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midRdata", rdata, 0);
    check("midStall", stall, 0);
    check("midDone", done, 0);
    check("midFault", fault, 0);
    modelReset();
    access(4, 0, 2, 0, 1, 0);
    for (int i = 0; i < 300; i++) begin
      int s, a;
      bit r, w;
      s = $urandom_range(0, 9) == 0 ? 3 : int'($urandom_range(0, 2));
      a = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, DEPTH + 6)) :
          int'($urandom_range(0, DEPTH - 1)) & ~((1 << s) - 1);
      r = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 15) == 0 ? 1'b1 : !r;
      access(32'(a), $urandom, s, 1'($urandom), r, w);
      if ($urandom_range(0, 2) == 0) idle();
    end
    rd = 0; wr = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
